// File: rtl/led_matrix_i2c_driver.sv
// Run-length encoding frame driver for an I2C LED matrix: power-up delay, chip init, LED enables, then PWM refreshes.
// Define LED_MATRIX_ABORT_RETRY_EN to retry aborted commands up to 3 times before flagging error.
module led_matrix_i2c_driver #(
    parameter int NUM_COLS        = 17,
    parameter int NUM_ROWS        = 7,
    parameter int REPEAT_SZ       = 6,
    parameter int POWER_UP_CYCLES = 50_000_000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 fb_we,
    input  logic [7:0]           fb_addr,
    input  logic [7:0]           fb_data,
    input  logic                 refresh_req,
    output logic                 activate,
    output logic [7:0]           location,
    output logic [7:0]           data,
    output logic [REPEAT_SZ-1:0] data_repeat,
    input  logic                 busy,
    input  logic                 abort,
    output logic                 ready,
    output logic                 refreshing,
    output logic                 error
);
    localparam int NUM_LEDS = NUM_COLS * NUM_ROWS;
    localparam int IDX_W    = $clog2(NUM_LEDS);
    localparam int RUN_W    = REPEAT_SZ + 1;

    localparam logic [7:0]       LEDS8   = 8'(NUM_LEDS);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(1 << REPEAT_SZ);

    typedef enum logic [2:0] {DELAY, INIT, ENABLES, IDLE, SCAN, SEND, AWAIT} state_t;
    typedef enum logic [1:0] {PH_INIT, PH_ENABLES, PH_FRAME} phase_t;

    state_t           state;
    phase_t           phase;
    logic [31:0]      delay_cnt;
    logic [4:0]       cmd_idx;
    logic [7:0]       run_start;
    logic [7:0]       scan_idx;
    logic [RUN_W-1:0] run_len;
    logic             seen_busy;
    logic             pending;
`ifdef LED_MATRIX_ABORT_RETRY_EN
    logic [1:0]       retry_cnt;
`endif

    logic [7:0] fb [NUM_LEDS];
    logic       fb_accept;
    logic       scan_more;
    logic       cmd_done;
    logic       cmd_retry;

    function automatic logic [15:0] init_cmd(input logic [4:0] idx);
        case (idx)
            5'd0:    return 16'hFD_0B;
            5'd1:    return 16'h0A_01;
            default: return 16'hFD_00;
        endcase
    endfunction

    // Bit b of enable byte k covers LED 8k+b; LEDs beyond the matrix stay off.
    function automatic logic [7:0] enable_mask(input logic [4:0] k);
        logic [7:0] m;
        m = '0;
        for (int b = 0; b < 8; b++) m[b] = (int'(k) * 8 + b) < NUM_LEDS;
        return m;
    endfunction

    assign fb_accept = fb_we && (fb_addr < LEDS8);
    assign scan_more = (scan_idx < LEDS8) && (run_len < RUN_MAX) &&
                       (fb[scan_idx[IDX_W-1:0]] == fb[run_start[IDX_W-1:0]]);

    // NOTE: the framebuffer must read back as zero after reset, so it is built from resettable flops rather than a RAM.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_LEDS; i++) fb[i] <= '0;
        end else if (fb_accept) begin
            fb[fb_addr[IDX_W-1:0]] <= fb_data;
        end
    end

    // NOTE: every output of a combinational block gets a default first so no path can infer a latch.
    always_comb begin
        cmd_done  = 1'b0;
        cmd_retry = 1'b0;
        if (state == AWAIT) begin
            if (abort) begin
`ifdef LED_MATRIX_ABORT_RETRY_EN
                cmd_retry = (retry_cnt < 2'd3);
                cmd_done  = !cmd_retry;
`else
                cmd_done  = 1'b1;
`endif
            end else begin
                cmd_done = seen_busy && !busy;
            end
        end
    end

    // NOTE: all state here is updated with non-blocking assignments so every register sees last cycle's values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= DELAY;
            phase       <= PH_INIT;
            delay_cnt   <= 32'(POWER_UP_CYCLES);
            cmd_idx     <= '0;
            run_start   <= '0;
            scan_idx    <= '0;
            run_len     <= '0;
            seen_busy   <= 1'b0;
            pending     <= 1'b0;
            activate    <= 1'b0;
            ready       <= 1'b0;
            refreshing  <= 1'b0;
            error       <= 1'b0;
            location    <= '0;
            data        <= '0;
            data_repeat <= '0;
`ifdef LED_MATRIX_ABORT_RETRY_EN
            retry_cnt   <= '0;
`endif
        end else begin
            case (state)
                DELAY: begin
                    if (delay_cnt <= 32'd1) state <= INIT;
                    else delay_cnt <= delay_cnt - 32'd1;
                end
                INIT: begin
                    {location, data} <= init_cmd(cmd_idx);
                    data_repeat      <= '0;
                    phase            <= PH_INIT;
                    state            <= SEND;
                end
                ENABLES: begin
                    location    <= {3'b000, cmd_idx};
                    data        <= enable_mask(cmd_idx);
                    data_repeat <= '0;
                    phase       <= PH_ENABLES;
                    state       <= SEND;
                end
                IDLE: begin
                    if (pending) begin
                        pending    <= 1'b0;
                        refreshing <= 1'b1;
                        ready      <= 1'b0;
                        run_start  <= '0;
                        scan_idx   <= 8'd1;
                        run_len    <= RUN_W'(1);
                        phase      <= PH_FRAME;
                        state      <= SCAN;
                    end
                end
                SCAN: begin
                    if (scan_more) begin
                        scan_idx <= scan_idx + 8'd1;
                        run_len  <= run_len + RUN_W'(1);
                    end else begin
                        location    <= 8'h24 + run_start;
                        data        <= fb[run_start[IDX_W-1:0]];
                        data_repeat <= REPEAT_SZ'(run_len - RUN_W'(1));
                        state       <= SEND;
                    end
                end
                SEND: begin
                    if (!busy) begin
                        activate  <= 1'b1;
                        seen_busy <= 1'b0;
                        state     <= AWAIT;
                    end
                end
                AWAIT: begin
                    if (!seen_busy && busy) begin
                        seen_busy <= 1'b1;
                        activate  <= 1'b0;
                    end
                    if (cmd_retry) begin
                        activate <= 1'b0;
`ifdef LED_MATRIX_ABORT_RETRY_EN
                        retry_cnt <= retry_cnt + 2'd1;
`endif
                        state <= SEND;
                    end else if (cmd_done) begin
                        activate  <= 1'b0;
                        seen_busy <= 1'b0;
`ifdef LED_MATRIX_ABORT_RETRY_EN
                        retry_cnt <= '0;
`endif
                        if (abort) error <= 1'b1;
                        case (phase)
                            PH_INIT: begin
                                if (cmd_idx == 5'd2) begin
                                    cmd_idx <= '0;
                                    state   <= ENABLES;
                                end else begin
                                    cmd_idx <= cmd_idx + 5'd1;
                                    state   <= INIT;
                                end
                            end
                            PH_ENABLES: begin
                                if (cmd_idx == 5'd17) begin
                                    pending <= 1'b1;
                                    ready   <= 1'b1;
                                    state   <= IDLE;
                                end else begin
                                    cmd_idx <= cmd_idx + 5'd1;
                                    state   <= ENABLES;
                                end
                            end
                            default: begin
                                // scan_idx sits one past the run, so reaching NUM_LEDS means the frame is done.
                                if (scan_idx == LEDS8) begin
                                    refreshing <= 1'b0;
                                    ready      <= 1'b1;
                                    state      <= IDLE;
                                end else begin
                                    run_start <= scan_idx;
                                    scan_idx  <= scan_idx + 8'd1;
                                    run_len   <= RUN_W'(1);
                                    state     <= SCAN;
                                end
                            end
                        endcase
                    end
                end
                default: state <= DELAY;
            endcase
            // A write or request arriving as IDLE consumes pending must still win.
            if (fb_accept || refresh_req) pending <= 1'b1;
        end
    end
endmodule

// File: tb/tb_led_matrix_i2c_driver.sv
// Self-checking bench for led_matrix_i2c_driver with a busy/abort controller model and a run-length frame model.
module tb_led_matrix_i2c_driver;
    localparam int NUM_COLS  = 17;
    localparam int NUM_ROWS  = 7;
    localparam int NUM_LEDS  = NUM_COLS * NUM_ROWS;
    localparam int REPEAT_SZ = 6;
    localparam int MAX_RUN   = 1 << REPEAT_SZ;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic fb_we = 1'b0;
    logic refresh_req = 1'b0;
    logic busy = 1'b0;
    logic abort = 1'b0;
    logic [7:0] fb_addr = '0;
    logic [7:0] fb_data = '0;
    logic activate, ready, refreshing, error;
    logic [7:0] location, data;
    logic [REPEAT_SZ-1:0] data_repeat;

    always #5 clk = ~clk;

    led_matrix_i2c_driver #(
        .NUM_COLS(NUM_COLS), .NUM_ROWS(NUM_ROWS), .REPEAT_SZ(REPEAT_SZ), .POWER_UP_CYCLES(10)
    ) dut (
        .clk(clk), .reset(reset), .fb_we(fb_we), .fb_addr(fb_addr), .fb_data(fb_data),
        .refresh_req(refresh_req), .activate(activate), .location(location), .data(data),
        .data_repeat(data_repeat), .busy(busy), .abort(abort), .ready(ready),
        .refreshing(refreshing), .error(error)
    );

    typedef struct packed {
        logic [7:0] loc;
        logic [7:0] val;
        logic [7:0] rep;
    } cmd_t;

    typedef struct {
        int         addr;
        logic [7:0] val;
        int         exp_cmds;
    } vec_t;

    cmd_t cmd_log[$];
    cmd_t exp_q[$];
    logic [7:0] shadow [NUM_LEDS];
    int total = 0;
    int bad = 0;
    int frames = 0;
    int frame_start = 0;
    int cycle = 0;
    int fall_cycle = 0;
    int rise_gap = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Controller model: busy for 5 cycles per command, optional abort pulse on a chosen command.
    int   busy_left = 0;
    int   abort_plan = 0;
    logic target_set = 1'b0;
    logic abort_this = 1'b0;
    cmd_t abort_target;
    always @(posedge clk) begin
        cmd_t cur;
        abort <= 1'b0;
        if (reset) begin
            busy <= 1'b0;
            busy_left = 0;
            abort_this = 1'b0;
        end else if (busy_left != 0) begin
            if (busy_left == 3 && abort_this) abort <= 1'b1;
            if (busy_left == 1) busy <= 1'b0;
            busy_left = busy_left - 1;
        end else if (activate) begin
            busy <= 1'b1;
            busy_left = 5;
            cur = '{location, data, 8'(data_repeat)};
            abort_this = 1'b0;
            if (abort_plan > 0 && location >= 8'h24 && (!target_set || cur == abort_target)) begin
                target_set = 1'b1;
                abort_target = cur;
                abort_plan--;
                abort_this = 1'b1;
            end
        end
    end

    // Monitor: logs every command at the activate rise, tracks frames, checks operands hold until busy falls.
    logic act_q = 1'b0, ref_q = 1'b0, busy_q = 1'b0, inflight = 1'b0, aborted = 1'b0;
    always @(negedge clk) begin
        cycle++;
        if (reset) begin
            inflight = 1'b0;
        end else begin
            if (activate && !act_q) begin
                cmd_log.push_back('{location, data, 8'(data_repeat)});
                inflight = 1'b1;
                aborted = 1'b0;
            end
            if (abort) aborted = 1'b1;
            if (inflight && busy_q && !busy) begin
                if (!aborted)
                    check("hold_during_cmd", 32'({location, data, 8'(data_repeat)}), 32'(cmd_log[$]));
                inflight = 1'b0;
            end
        end
        if (refreshing && !ref_q) begin
            frames++;
            frame_start = cmd_log.size();
            rise_gap = cycle - fall_cycle;
        end
        if (!refreshing && ref_q) fall_cycle = cycle;
        act_q = activate;
        ref_q = refreshing;
        busy_q = busy;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic write_px(input int addr, input logic [7:0] val);
        @(negedge clk);
        fb_we = 1'b1;
        fb_addr = 8'(addr);
        fb_data = val;
        @(negedge clk);
        fb_we = 1'b0;
        if (addr < NUM_LEDS) shadow[addr] = val;
    endtask

    task automatic pulse_refresh();
        @(negedge clk);
        refresh_req = 1'b1;
        @(negedge clk);
        refresh_req = 1'b0;
    endtask

    task automatic wait_quiet(input string name);
        int run = 0;
        logic ok = 1'b0;
        for (int c = 0; c < 5000 && !ok; c++) begin
            @(negedge clk);
            if (ready) run++;
            else run = 0;
            if (run >= 4) ok = 1'b1;
        end
        check({name, "_quiet"}, 32'(ok), 32'd1);
    endtask

    // Reference frame: greedy runs of equal pixels capped at 2^REPEAT_SZ.
    task automatic build_frame();
        int s = 0;
        exp_q.delete();
        while (s < NUM_LEDS) begin
            int len = 1;
            while (s + len < NUM_LEDS && shadow[s + len] == shadow[s] && len < MAX_RUN) len++;
            exp_q.push_back('{8'(8'h24 + s), shadow[s], 8'(len - 1)});
            s += len;
        end
    endtask

    task automatic compare_frame(input string tag);
        int n;
        build_frame();
        n = cmd_log.size() - frame_start;
        check({tag, "_frame_len"}, 32'(n), 32'(exp_q.size()));
        for (int i = 0; i < n && i < exp_q.size(); i++)
            check($sformatf("%s_cmd%0d", tag, i), 32'(cmd_log[frame_start + i]), 32'(exp_q[i]));
    endtask

    task automatic check_boot(input string tag);
        cmd_t e;
        logic [7:0] m;
        logic [15:0] init_tab [3];
        init_tab[0] = 16'hFD0B;
        init_tab[1] = 16'h0A01;
        init_tab[2] = 16'hFD00;
        check({tag, "_frame_start"}, 32'(frame_start), 32'd21);
        check({tag, "_total_cmds"}, 32'(cmd_log.size()), 32'd23);
        for (int k = 0; k < 3 && k < cmd_log.size(); k++) begin
            e = '{init_tab[k][15:8], init_tab[k][7:0], 8'd0};
            check($sformatf("%s_init%0d", tag, k), 32'(cmd_log[k]), 32'(e));
        end
        for (int k = 0; k < 18 && 3 + k < cmd_log.size(); k++) begin
            m = '0;
            for (int b = 0; b < 8; b++) if (8 * k + b < NUM_LEDS) m[b] = 1'b1;
            e = '{8'(k), m, 8'd0};
            check($sformatf("%s_enable%0d", tag, k), 32'(cmd_log[3 + k]), 32'(e));
        end
        if (cmd_log.size() >= 21) begin
            check({tag, "_e14"}, 32'(cmd_log[17].val), 32'h7F);
            check({tag, "_e15_17"}, 32'(cmd_log[18].val | cmd_log[19].val | cmd_log[20].val), 32'h00);
        end
        compare_frame(tag);
        check({tag, "_ready"}, 32'(ready), 32'd1);
        check({tag, "_refreshing"}, 32'(refreshing), 32'd0);
        check({tag, "_error"}, 32'(error), 32'd0);
    endtask

    initial begin
        vec_t vecs[6];
        int prev;
        int n_before, f_before, issues, nz;
        logic got;
        vecs[0] = '{5,   8'hFF, 4};
        vecs[1] = '{0,   8'h10, 3};
        vecs[2] = '{118, 8'h01, 3};
        vecs[3] = '{64,  8'h22, 3};
        vecs[4] = '{63,  8'h33, 3};
        vecs[5] = '{119, 8'h55, 0};
        for (int i = 0; i < NUM_LEDS; i++) shadow[i] = 8'h00;

        // Reset state
        tick(3);
        check("rst_activate", 32'(activate), 32'd0);
        check("rst_ready", 32'(ready), 32'd0);
        check("rst_refreshing", 32'(refreshing), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        check("rst_operands", 32'({location, data, 8'(data_repeat)}), 32'd0);
        cmd_log.delete();
        reset = 1'b0;
        wait_quiet("boot");
        check_boot("boot");

        // Single-pixel frames from a zero framebuffer
        prev = -1;
        foreach (vecs[v]) begin
            if (prev >= 0) begin
                write_px(prev, 8'h00);
                wait_quiet($sformatf("clear%0d", v));
            end
            n_before = cmd_log.size();
            f_before = frames;
            write_px(vecs[v].addr, vecs[v].val);
            wait_quiet($sformatf("vec%0d", v));
            if (vecs[v].exp_cmds == 0) begin
                check("ignored_cmds", 32'(cmd_log.size() - n_before), 32'd0);
                check("ignored_frames", 32'(frames - f_before), 32'd0);
                check("ignored_pending", 32'(dut.pending), 32'd0);
                prev = -1;
            end else begin
                check($sformatf("vec%0d_frames", v), 32'(frames - f_before), 32'd1);
                check($sformatf("vec%0d_table_len", v), 32'(cmd_log.size() - frame_start), 32'(vecs[v].exp_cmds));
                compare_frame($sformatf("vec%0d", v));
                prev = vecs[v].addr;
            end
        end

        // Write during the second command of a refresh forces an immediate second refresh
        f_before = frames;
        pulse_refresh();
        got = 1'b0;
        for (int c = 0; c < 2000 && !got; c++) begin
            @(negedge clk);
            if (frames == f_before + 1 && cmd_log.size() - frame_start >= 2) got = 1'b1;
        end
        check("midframe_reach_cmd2", 32'(got), 32'd1);
        write_px(3, 8'h77);
        wait_quiet("midframe");
        check("midframe_frames", 32'(frames - f_before), 32'd2);
        check("midframe_gap_small", 32'(rise_gap <= 2), 32'd1);
        compare_frame("midframe");

        // Randomized bursts, some landing mid-refresh
        for (int r = 0; r < 4; r++) begin
            int nw = $urandom_range(1, 10);
            for (int w = 0; w < nw; w++) begin
                logic [7:0] val;
                case ($urandom_range(0, 2))
                    0:       val = 8'h00;
                    1:       val = 8'hA5;
                    default: val = 8'($urandom);
                endcase
                write_px($urandom_range(0, NUM_LEDS - 1), val);
                tick($urandom_range(0, 40));
            end
            wait_quiet($sformatf("rand%0d", r));
            compare_frame($sformatf("rand%0d", r));
        end

        // Two aborts on the first PWM command
        check("abort_pre_error", 32'(error), 32'd0);
        target_set = 1'b0;
        abort_plan = 2;
        pulse_refresh();
        wait_quiet("abort");
        abort_plan = 0;
        build_frame();
        issues = 0;
        for (int i = frame_start; i < cmd_log.size(); i++)
            if (cmd_log[i] == exp_q[0]) issues++;
        check("abort_first_cmd", 32'(cmd_log[frame_start]), 32'(exp_q[0]));
`ifdef LED_MATRIX_ABORT_RETRY_EN
        check("abort_issues", 32'(issues), 32'd3);
        check("abort_error", 32'(error), 32'd0);
        check("abort_frame_len", 32'(cmd_log.size() - frame_start), 32'(exp_q.size() + 2));
`else
        check("abort_issues", 32'(issues), 32'd1);
        check("abort_error", 32'(error), 32'd1);
        check("abort_frame_len", 32'(cmd_log.size() - frame_start), 32'(exp_q.size()));
`endif

        // Reset in the middle of a command
        f_before = frames;
        pulse_refresh();
        got = 1'b0;
        for (int c = 0; c < 2000 && !got; c++) begin
            @(negedge clk);
            if (frames > f_before && cmd_log.size() > frame_start && busy) got = 1'b1;
        end
        check("midcmd_reach_busy", 32'(got), 32'd1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_activate", 32'(activate), 32'd0);
        check("midrst_ready", 32'(ready), 32'd0);
        check("midrst_refreshing", 32'(refreshing), 32'd0);
        check("midrst_error", 32'(error), 32'd0);
        check("midrst_operands", 32'({location, data, 8'(data_repeat)}), 32'd0);
        nz = 0;
        for (int i = 0; i < NUM_LEDS; i++) if (dut.fb[i] != 8'h00) nz++;
        check("midrst_fb_nonzero", 32'(nz), 32'd0);
        for (int i = 0; i < NUM_LEDS; i++) shadow[i] = 8'h00;
        @(negedge clk);
        cmd_log.delete();
        frame_start = 0;
        reset = 1'b0;
        wait_quiet("reboot");
        check_boot("reboot");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/led_matrix_i2c_driver.md
LED_MATRIX_I2C_DRIVER -- requirements
Module: led_matrix_i2c_driver

Interface
REQ-001 SHALL have parameter NUM_COLS, default 17, matrix columns.
REQ-002 SHALL have parameter NUM_ROWS, default 7, matrix rows; NUM_LEDS = NUM_COLS*NUM_ROWS, required to be 144 or fewer.
REQ-003 SHALL have parameter REPEAT_SZ, default 6, width of data_repeat; max run length = 2^REPEAT_SZ.
REQ-004 SHALL have parameter POWER_UP_CYCLES, default 50_000_000, post-reset delay in clk cycles.
REQ-005 SHALL have port clk, input, 1, sole clock; all logic on its rising edge.
REQ-006 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-007 SHALL have port fb_we, input, 1, framebuffer write strobe.
REQ-008 SHALL have port fb_addr, input, 8, pixel index row*NUM_COLS+col; writes with fb_addr >= NUM_LEDS are ignored.
REQ-009 SHALL have port fb_data, input, 8, pixel PWM brightness.
REQ-010 SHALL have port refresh_req, input, 1, one-cycle request to resend the whole frame.
REQ-011 SHALL have port activate, output, 1, command strobe to the I2C controller.
REQ-012 SHALL have port location, output, 8, register address.
REQ-013 SHALL have port data, output, 8, register value.
REQ-014 SHALL have port data_repeat, output, REPEAT_SZ, extra repeated writes.
REQ-015 SHALL have port busy, input, 1, from the I2C controller.
REQ-016 SHALL have port abort, input, 1, one-cycle failure pulse from the I2C controller.
REQ-017 SHALL have port ready, output, 1, init done and idle.
REQ-018 SHALL have port refreshing, output, 1, high while a refresh is in progress.
REQ-019 SHALL have port error, output, 1, sticky flag set on an unrecovered abort.

Function
REQ-020 SHALL run states DELAY -> INIT -> ENABLES -> IDLE <-> SCAN -> SEND -> AWAIT -> (SCAN | IDLE).
REQ-021 DELAY SHALL count POWER_UP_CYCLES cycles, then enter INIT.
REQ-022 INIT SHALL issue three commands in this order: (0xFD,0x0B), (0x0A,0x01), (0xFD,0x00); repeat = 0 for each.
REQ-023 ENABLES SHALL issue 18 commands, (k, E_k) for k = 0..17, where bit b of E_k = 1 iff 8k+b < NUM_LEDS.
REQ-024 SHALL hold a framebuffer of NUM_LEDS x 8 bits, reset to 0; fb_we writes it in any state, taking effect the next cycle.
REQ-025 SHALL set a pending flag on any accepted fb_we or on refresh_req; pending SHALL be set at the end of ENABLES so a first full frame is always sent.
REQ-026 In IDLE with pending set, the block SHALL clear pending, raise refreshing and enter SCAN with run start s = 0.
REQ-027 SCAN SHALL examine one pixel per cycle and extend the run while fb[i] == fb[s], i < NUM_LEDS and length < 2^REPEAT_SZ.
REQ-028 Each run SHALL produce one command: location = 0x24 + s, data = fb[s], data_repeat = length - 1.
REQ-029 SCAN SHALL read the current framebuffer contents; a write landing during a refresh sets pending, so a further full refresh follows.
REQ-030 SEND SHALL wait for busy = 0, then drive location, data and data_repeat and assert activate.
REQ-031 AWAIT SHALL hold activate until busy is first seen high, then deassert activate; the command completes when busy is next seen low.
REQ-032 location, data and data_repeat SHALL be stable from the activate rise until completion.
REQ-033 After the run that ends at pixel NUM_LEDS-1 completes, the block SHALL drop refreshing and return to IDLE; ready = 1 only in IDLE.
REQ-034 A full frame of uniform value SHALL need ceil(NUM_LEDS / 2^REPEAT_SZ) commands; 119 LEDs at REPEAT_SZ 6 gives 2 commands (repeat 63, then repeat 54).
REQ-035 An abort seen in AWAIT SHALL be handled per the Configuration section.

Reset
REQ-036 Reset SHALL force state DELAY, reload the delay counter and clear pending and the framebuffer.
REQ-037 Reset SHALL drive activate = 0, ready = 0, refreshing = 0, error = 0, location = 0, data = 0 and data_repeat = 0.
REQ-038 Reset asserted mid-command SHALL take effect the next cycle; no command is resumed.

Configuration
REQ-039 Macro LED_MATRIX_ABORT_RETRY_EN selects abort handling.
REQ-040 With LED_MATRIX_ABORT_RETRY_EN defined, an abort SHALL reissue the same command through SEND, up to 3 retries.
REQ-041 With LED_MATRIX_ABORT_RETRY_EN defined, a 4th abort on the same command SHALL set error and treat the command as complete.
REQ-042 Without LED_MATRIX_ABORT_RETRY_EN, any abort SHALL set error and the command SHALL be treated as complete.

Verification
REQ-043 Reset, POWER_UP_CYCLES = 10, controller model with busy for 5 cycles -> exactly 21 init/enable commands; E_14 = 0x7F, E_15..E_17 = 0x00; then a 2-command zero frame; ready = 1.
REQ-044 Write pixel 5 = 0xFF, others 0 -> 4 commands: (0x24,0x00,r4), (0x29,0xFF,r0), (0x2A,0x00,r63), (0x6A,0x00,r48).
REQ-045 Write pixel 3 during the second command of a refresh -> a second full refresh starts immediately after the first completes.
REQ-046 Model aborts the first PWM command twice -> with the macro: 3 issues of the same command and error = 0; without the macro: 1 issue and error = 1.
REQ-047 Reset asserted while busy = 1 mid-frame -> next cycle activate = 0, state DELAY and all framebuffer entries read 0.
REQ-048 fb_addr = 119 with NUM_COLS 17 x NUM_ROWS 7 -> write ignored, pending unchanged, no refresh.
